// File: rtl/noc_out_lock_mux.sv
// ============================================================================
// Module   : noc_out_lock_mux
// Brief    : NoC output-port switch stage. Requests arbitration for head flits,
//            locks the output to the granted input until the tail flit passes,
//            and forwards flits through a single-entry output register.
//            Optional stall watchdog enabled by defining NOC_OUT_LOCK_WDT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module noc_out_lock_mux #(
    parameter int FLIT_WIDTH = 32,
    parameter int WDT_CYCLES = 64
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic [1:0]              in_valid_i,
    output logic [1:0]              in_ready_o,
    input  logic [2*FLIT_WIDTH-1:0] in_data_i,
    input  logic [3:0]              in_type_i,
    output logic [1:0]              req_o,
    input  logic [1:0]              grant_i,
    output logic                    update_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [FLIT_WIDTH-1:0]   out_data_o,
    output logic [1:0]              out_type_o,
    output logic                    locked_o,
    output logic                    owner_o,
    output logic                    wdt_err_o
);

    localparam logic [1:0] c_HEAD      = 2'b00;
    localparam logic [1:0] c_TAIL      = 2'b10;
    localparam logic [1:0] c_HEAD_TAIL = 2'b11;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    logic                    r_owner;
    logic                    r_out_valid;
    logic [FLIT_WIDTH-1:0]   r_out_data;
    logic [1:0]              r_out_type;

    logic                    w_idle;
    logic                    w_can_load;
    logic                    w_grant_ok;
    logic                    w_gidx;
    logic                    w_idle_xfer;
    logic                    w_lock_xfer;
    logic                    w_xfer;
    logic                    w_sel;
    logic [1:0]              w_req;
    logic [1:0]              w_ready;
    logic [1:0]              w_sel_type;
    logic [FLIT_WIDTH-1:0]   w_sel_data;

    always_comb begin
        w_idle     = (r_state == ST_IDLE);
        w_can_load = !r_out_valid || out_ready_i;
        w_req      = 2'b00;
        for (int n = 0; n < 2; n++) begin
            w_req[n] = w_idle && in_valid_i[n] &&
                       ((in_type_i[2*n +: 2] == c_HEAD) || (in_type_i[2*n +: 2] == c_HEAD_TAIL));
        end
        // Only a clean one-hot grant aimed at a requesting input counts.
        w_grant_ok  = ((grant_i == 2'b01) && w_req[0]) || ((grant_i == 2'b10) && w_req[1]);
        w_gidx      = grant_i[1];
        w_idle_xfer = w_grant_ok && w_can_load;
        w_lock_xfer = !w_idle && in_valid_i[r_owner] && w_can_load;
        w_xfer      = w_idle_xfer || w_lock_xfer;
        w_sel       = w_idle ? w_gidx : r_owner;
        w_sel_data  = w_sel ? in_data_i[2*FLIT_WIDTH-1:FLIT_WIDTH] : in_data_i[FLIT_WIDTH-1:0];
        w_sel_type  = w_sel ? in_type_i[3:2] : in_type_i[1:0];
        w_ready     = 2'b00;
        if (w_idle_xfer) begin
            w_ready[w_gidx] = 1'b1;
        end else if (!w_idle) begin
            w_ready[r_owner] = w_can_load;
        end
    end

    assign req_o       = w_req;
    assign in_ready_o  = w_ready;
    assign update_o    = w_idle_xfer;
    assign out_valid_o = r_out_valid;
    assign out_data_o  = r_out_data;
    assign out_type_o  = r_out_type;
    assign locked_o    = (r_state == ST_LOCKED);
    assign owner_o     = r_owner;

    always_ff @(posedge clk) begin
        if (arst) begin
            r_state     <= ST_IDLE;
            r_owner     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_type  <= 2'b00;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_type  <= w_sel_type;
            end else if (out_ready_i) begin
                r_out_valid <= 1'b0;
            end
            // A tail leaves LOCKED; the next head is arbitrated from IDLE a cycle later.
            if (w_idle_xfer) begin
                r_owner <= w_gidx;
                if (w_sel_type == c_HEAD) begin
                    r_state <= ST_LOCKED;
                end
            end else if (w_lock_xfer && (w_sel_type == c_TAIL)) begin
                r_state <= ST_IDLE;
            end
        end
    end

`ifdef NOC_OUT_LOCK_WDT_EN
    localparam int c_WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [c_WDT_W-1:0] c_WDT_MAX = c_WDT_W'(WDT_CYCLES);

    logic [c_WDT_W-1:0] r_wdt_cnt;
    logic               r_wdt_err;
    logic               w_stall;

    assign w_stall   = !w_idle && !in_valid_i[r_owner];
    assign wdt_err_o = r_wdt_err;

    // Error is raised on the edge where the count reaches the threshold; the lock is never aborted.
    always_ff @(posedge clk) begin
        if (arst) begin
            r_wdt_cnt <= '0;
            r_wdt_err <= 1'b0;
        end else if (w_stall) begin
            if (r_wdt_cnt != c_WDT_MAX) begin
                r_wdt_cnt <= r_wdt_cnt + 1'b1;
            end
            if (r_wdt_cnt >= c_WDT_MAX - 1'b1) begin
                r_wdt_err <= 1'b1;
            end
        end else begin
            r_wdt_cnt <= '0;
        end
    end
`else
    assign wdt_err_o = 1'b0;

    if (WDT_CYCLES < 1) begin : g_wdt_cfg_unused
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_noc_out_lock_mux.sv
// ============================================================================
// Module   : tb_noc_out_lock_mux
// Brief    : Directed self-checking bench for noc_out_lock_mux.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_noc_out_lock_mux;

    localparam int FW = 32;

`ifdef NOC_OUT_LOCK_WDT_EN
    localparam logic c_EXP_WDT = 1'b1;
`else
    localparam logic c_EXP_WDT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            arst;
    logic [1:0]      in_valid_i;
    logic [1:0]      in_ready_o;
    logic [2*FW-1:0] in_data_i;
    logic [3:0]      in_type_i;
    logic [1:0]      req_o;
    logic [1:0]      grant_i;
    logic            update_o;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [FW-1:0]   out_data_o;
    logic [1:0]      out_type_o;
    logic            locked_o;
    logic            owner_o;
    logic            wdt_err_o;

    logic [1:0]      grant_drv;
    logic [1:0]      arb_grant;
    logic            use_arb;
    logic            arb_last;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign grant_i = use_arb ? arb_grant : grant_drv;

    // Reference 2-requester round-robin arbiter for the contention phase.
    always_comb begin
        arb_grant = req_o;
        if (req_o == 2'b11) arb_grant = arb_last ? 2'b01 : 2'b10;
    end

    always @(posedge clk) begin
        if (arst) arb_last <= 1'b1;
        else if (update_o) arb_last <= grant_i[1];
    end

    noc_out_lock_mux #(.FLIT_WIDTH(FW), .WDT_CYCLES(4)) dut (
        .clk(clk), .arst(arst),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .in_data_i(in_data_i), .in_type_i(in_type_i),
        .req_o(req_o), .grant_i(grant_i), .update_o(update_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_data_o(out_data_o), .out_type_o(out_type_o),
        .locked_o(locked_o), .owner_o(owner_o), .wdt_err_o(wdt_err_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int n, input logic v, input logic [1:0] t, input logic [FW-1:0] d);
        in_valid_i[n]       = v;
        in_type_i[2*n +: 2] = t;
        in_data_i[FW*n +: FW] = d;
    endtask

    initial begin
        int ptr0;
        int ptr1;
        int upd;
        int cyc;
        logic [FW-1:0] q[$];
        logic [FW-1:0] expd;

        arst = 1'b1; in_valid_i = 2'b00; in_data_i = '0; in_type_i = 4'h0;
        grant_drv = 2'b00; use_arb = 1'b0; out_ready_i = 1'b1;
        tick(); tick();
        chk("reset_outs", {out_valid_o, out_data_o, out_type_o, locked_o, owner_o, update_o, wdt_err_o}, '0);
        arst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_outs", {out_valid_o, out_data_o, out_type_o, locked_o, owner_o,
                              update_o, wdt_err_o, req_o, in_ready_o}, '0);
        end

        // Single 3-flit packet on input 0
        drive(0, 1'b1, 2'b00, 32'hA); grant_drv = 2'b01; #1;
        chk("pkt_head_req", req_o, 2'b01);
        chk("pkt_head_update", update_o, 1'b1);
        chk("pkt_head_ready", in_ready_o, 2'b01);
        tick();
        chk("pkt_head_out", {out_valid_o, out_data_o, out_type_o, locked_o, owner_o}, {1'b1, 32'hA, 2'b00, 1'b1, 1'b0});
        drive(0, 1'b1, 2'b01, 32'hB); #1;
        chk("pkt_body_req", req_o, 2'b00);
        chk("pkt_body_update", update_o, 1'b0);
        chk("pkt_body_ready", in_ready_o, 2'b01);
        tick();
        chk("pkt_body_out", {out_data_o, out_type_o, locked_o}, {32'hB, 2'b01, 1'b1});
        drive(0, 1'b1, 2'b10, 32'hC); #1;
        tick();
        chk("pkt_tail_out", {out_data_o, out_type_o, locked_o}, {32'hC, 2'b10, 1'b0});
        drive(0, 1'b0, 2'b00, 32'h0); grant_drv = 2'b00;
        tick();
        chk("pkt_drain", out_valid_o, 1'b0);

        // Backpressure mid-packet on input 1
        drive(1, 1'b1, 2'b00, 32'h10); grant_drv = 2'b10;
        tick();
        chk("bp_head", {out_data_o, owner_o, locked_o}, {32'h10, 1'b1, 1'b1});
        grant_drv = 2'b00; out_ready_i = 1'b0;
        drive(1, 1'b1, 2'b01, 32'h11); #1;
        chk("bp_ready_low", in_ready_o, 2'b00);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold", {out_valid_o, out_data_o}, {1'b1, 32'h10});
        end
        out_ready_i = 1'b1; #1;
        chk("bp_ready_resume", in_ready_o, 2'b10);
        tick();
        chk("bp_body", out_data_o, 32'h11);
        drive(1, 1'b1, 2'b10, 32'h12);
        tick();
        chk("bp_tail", {out_data_o, out_type_o, locked_o}, {32'h12, 2'b10, 1'b0});
        drive(1, 1'b0, 2'b00, 32'h0);
        tick();
        chk("bp_no_dup", out_valid_o, 1'b0);

        // HEAD_TAIL and bad grants
        drive(1, 1'b1, 2'b11, 32'h55); grant_drv = 2'b10; #1;
        chk("ht_update", update_o, 1'b1);
        chk("ht_ready", in_ready_o, 2'b10);
        tick();
        chk("ht_out", {out_valid_o, out_data_o, out_type_o, locked_o}, {1'b1, 32'h55, 2'b11, 1'b0});
        drive(1, 1'b1, 2'b11, 32'h66); grant_drv = 2'b11; #1;
        chk("g11_req", req_o, 2'b10);
        chk("g11_noxfer", {update_o, in_ready_o}, 3'b000);
        tick();
        chk("g11_out_idle", out_valid_o, 1'b0);
        grant_drv = 2'b01; #1;
        chk("gwrong_noxfer", {update_o, in_ready_o}, 3'b000);
        drive(1, 1'b0, 2'b00, 32'h0);
        drive(0, 1'b1, 2'b01, 32'h99); #1;
        chk("idle_body_req", req_o, 2'b00);
        chk("idle_body_ready", in_ready_o, 2'b00);
        tick();
        chk("idle_body_out", out_valid_o, 1'b0);

        // Watchdog: owner silent after HEAD
        drive(0, 1'b1, 2'b00, 32'h77); grant_drv = 2'b01;
        tick();
        drive(0, 1'b0, 2'b00, 32'h0); grant_drv = 2'b00;
        tick(); tick(); tick();
        chk("wdt_before", wdt_err_o, 1'b0);
        tick();
        chk("wdt_trip", {wdt_err_o, locked_o}, {c_EXP_WDT, 1'b1});
        drive(0, 1'b1, 2'b10, 32'h78);
        tick();
        chk("wdt_tail", {out_data_o, locked_o, wdt_err_o}, {32'h78, 1'b0, c_EXP_WDT});
        drive(0, 1'b0, 2'b00, 32'h0);
        tick();
        chk("wdt_sticky", wdt_err_o, c_EXP_WDT);

        // Contention under the reference arbiter: 4 packets of 3 flits per input
        arst = 1'b1; tick(); tick(); arst = 1'b0;
        chk("wdt_cleared", wdt_err_o, 1'b0);
        use_arb = 1'b1;
        ptr0 = 0; ptr1 = 0; upd = 0; cyc = 0;
        while (!(ptr0 == 12 && ptr1 == 12) && cyc < 200) begin
            drive(0, ptr0 < 12, (ptr0 % 3 == 0) ? 2'b00 : (ptr0 % 3 == 1) ? 2'b01 : 2'b10, 32'(ptr0));
            drive(1, ptr1 < 12, (ptr1 % 3 == 0) ? 2'b00 : (ptr1 % 3 == 1) ? 2'b01 : 2'b10, 32'(256 + ptr1));
            #1;
            if (update_o) upd++;
            if (in_valid_i[0] && in_ready_o[0]) ptr0++;
            if (in_valid_i[1] && in_ready_o[1]) ptr1++;
            tick();
            if (out_valid_o) q.push_back(out_data_o);
            cyc++;
        end
        in_valid_i = 2'b00;
        chk("cont_done", cyc < 200, 1'b1);
        chk("cont_updates", upd, 8);
        chk("cont_len", q.size(), 24);
        for (int pk = 0; pk < 8; pk++) begin
            for (int f = 0; f < 3; f++) begin
                expd = 32'((pk % 2) * 256 + (pk / 2) * 3 + f);
                chk("cont_flit", (pk * 3 + f < q.size()) ? q[pk * 3 + f] : 32'hFFFF_FFFF, expd);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/noc_out_lock_mux.md
Name: noc_out_lock_mux

Overview:
- Output-port switch stage that sits directly downstream of the 2-requester round-robin arbiter in the NoC router.
- Turns head flits from two input buffers into `req_o` for the arbiter.
- Consumes the arbiter's `grant_i` and locks the output to the granted input until that packet's tail flit passes.
- Pulses `update_o` so the arbiter advances its priority mask, and forwards flits through a single-entry output register.

Parameters:
- FLIT_WIDTH, 32, payload bits per flit
- WDT_CYCLES, 64, stall threshold in cycles for the optional watchdog (used only when the feature macro is defined)

Ports:
- clk  in  1  clock
- arst  in  1  reset; synchronous, active-high, sampled on rising edge of clk
- in_valid_i  in  2  per-input flit valid
- in_ready_o  out  2  per-input flit accept
- in_data_i  in  2*FLIT_WIDTH  flit payload; input n occupies bits [n*FLIT_WIDTH +: FLIT_WIDTH]
- in_type_i  in  4  flit type, 2 bits per input: 00 HEAD, 01 BODY, 10 TAIL, 11 HEAD_TAIL
- req_o  out  2  request vector to the arbiter (drives its req_i)
- grant_i  in  2  one-hot grant from the arbiter (its grant_o)
- update_o  out  1  one-cycle pulse that advances the arbiter mask (drives its update_i)
- out_valid_o  out  1  output flit valid
- out_ready_i  in  1  downstream accept
- out_data_o  out  FLIT_WIDTH  output payload
- out_type_o  out  2  output flit type
- locked_o  out  1  1 while the state machine is in LOCKED
- owner_o  out  1  index of the input currently owning the output
- wdt_err_o  out  1  sticky watchdog error

Behaviour:
- Reset values: state IDLE, out_valid_o=0, out_data_o=0, out_type_o=0, owner_o=0, locked_o=0, update_o=0, wdt_err_o=0.
- Reset asserted mid-packet discards the held flit and the lock; there is no recovery of partial packets.
- can_load = !out_valid_o || out_ready_i. The output register loads on a transfer and clears valid when out_ready_i=1 and nothing loads.
- Latency: an accepted input flit appears on out_* in the next cycle.
- IDLE state:
  - req_o[n] = in_valid_i[n] && type in {HEAD, HEAD_TAIL}.
  - A BODY or TAIL flit at the head of an input in IDLE is never requested and never accepted; it stalls that input.
  - Grant is valid when grant_i is one-hot and grant_i[n] & req_o[n].
  - With a valid grant and can_load: in_ready_o[n]=1, the flit transfers, update_o=1 (combinational, same cycle), owner_o<=n.
  - After the transfer, a HEAD flit moves the state to LOCKED; a HEAD_TAIL flit stays in IDLE.
  - grant_i=00, grant_i=11, a grant for a non-requesting input, or can_load=0 produce no transfer and update_o=0.
- LOCKED state:
  - req_o=00 and update_o=0.
  - in_ready_o[owner]=can_load; the other input's ready is 0.
  - Flits from the owner transfer whenever in_valid_i[owner] && can_load.
  - A TAIL transfer returns the state to IDLE in the next cycle.
  - HEAD or HEAD_TAIL flits arriving from the owner while LOCKED are forwarded unchanged (protocol violation, no check).
- A tail transfer and a new arbitration never occur in the same cycle; the new head is arbitrated from IDLE one cycle later.
- update_o pulses exactly once per packet.

Optional Feature:
- Macro: NOC_OUT_LOCK_WDT_EN.
- Defined:
  - A counter tracks consecutive cycles in LOCKED with in_valid_i[owner]=0; its width is clog2(WDT_CYCLES+1).
  - The counter clears on any owner valid or when leaving LOCKED, and saturates.
  - When the count reaches WDT_CYCLES, wdt_err_o<=1, sticky until arst.
  - The watchdog never aborts the lock.
- Undefined: no counter logic; wdt_err_o is tied to 0.

Test Plan:
- Reset then idle: arst=1 for 2 cycles, then release with no valid inputs -> all outputs 0 and req_o=00 for 10 cycles.
- Single packet: input0 sends HEAD(0xA), BODY(0xB), TAIL(0xC) with grant_i=01 and out_ready_i=1 ->
  - req_o=01 then 00;
  - update_o high for exactly 1 cycle;
  - out_data_o shows 0xA, 0xB, 0xC on consecutive cycles, one cycle after each accept;
  - locked_o=1 for 2 cycles; return to IDLE.
- Contention under a real arbiter: both inputs offer 3-flit packets, back to back, 4 packets each -> output alternates between the inputs with whole packets never interleaved, and the update_o count equals 8.
- Backpressure: out_ready_i=0 for 5 cycles mid-packet ->
  - out_data_o holds its value;
  - in_ready_o[owner]=0 after the register fills;
  - no flit is lost or duplicated after release.
- HEAD_TAIL plus bad grants: input1 sends HEAD_TAIL with grant_i=10 -> 1-cycle transfer, locked_o stays 0. grant_i=11 -> no transfer, update_o=0.
- Watchdog (macro defined, WDT_CYCLES=4): after a HEAD, hold in_valid_i[owner]=0 for 4 cycles -> wdt_err_o=1 and stays 1 through the following TAIL. With the macro undefined -> wdt_err_o=0.
